fadd_rr_sched: RTL and testbench
================================

// Module: fadd_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one combinational single-precision
//   float adder among N requesters. Each accepted operand pair is
//   registered into an issue stage (S1) that drives the adder. The sum is
//   captured in a result stage (S2) and returned on one tagged output port
//   with valid/ready backpressure. Sits between compute clients and the
//   shared adder datapath.
// PARAMETERS
//   N     4  number of requesters, 2..16
//   ID_W  2  requester-id width, 2**ID_W >= N
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   req_valid  in   N       per-requester operand pair valid
//   req_ready  out  N       per-requester accept; at most one bit set
//   req_a      in   N*32    operand A; requester i on bits [32*i+31:32*i]
//   req_b      in   N*32    operand B; same packing as req_a
//   fa_a       out  32      shared adder operand A, from S1 register
//   fa_b       out  32      shared adder operand B, from S1 register
//   fa_sum     in   32      shared adder result, combinational from fa_a/fa_b
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts the result
//   out_data   out  32      sum
//   out_id     out  ID_W    requester index that issued the op
//   ops_done   out  32      count of completed output handshakes
// BEHAVIOUR
//   - Reset (async, rst=1):
//     - s1_valid = s2_valid = 0; rr pointer = 0.
//     - fa_a, fa_b, out_data, out_id and ops_done are all 0.
//     - In-flight ops are discarded and never produce an output.
//     - req_ready = 0 while rst is high.
//   - Stall rules:
//     - s2_adv = !s2_valid | out_ready.
//     - s1_adv = s1_valid & s2_adv.
//     - s1_load = !s1_valid | s2_adv.
//   - Arbitration (combinational):
//     - grant = first i with req_valid[i] set, searching from ptr upward
//       and wrapping modulo N.
//     - req_ready[i] = grant[i] & s1_load.
//     - req_ready may depend on req_valid within the same cycle.
//   - Accept: on req_valid[i] & req_ready[i]:
//     - S1 <= {req_a[i], req_b[i], id=i}; s1_valid <= 1.
//     - ptr <= (i+1) mod N.
//     - With no accept, ptr holds.
//   - If s1_load but no request: s1_valid <= 0 and the S1 data regs hold.
//     fa_a/fa_b always reflect the S1 regs.
//   - S2 capture: when s1_adv, S2 <= {fa_sum, s1_id} and s2_valid <= 1.
//     Else, when out_ready & s2_valid: s2_valid <= 0.
//   - Output handshake: out_valid = s2_valid. out_data and out_id stay
//     stable while out_valid & !out_ready.
//   - ops_done increments on out_valid & out_ready and wraps at 2**32.
//   - Latency: accept at edge t -> out_valid high after edge t+1, i.e.
//     2 cycles when out_ready is high.
//   - Throughput: 1 op/cycle sustained. Accept, S1->S2 move and output
//     handshake may all occur in the same cycle.
//   - Full pipeline (both stages valid, out_ready=0): req_ready = 0.
//     No data is lost or duplicated.
//   - Fairness: a requester holding req_valid is granted within N accepts.
//   - Order: results leave in accept order.
// TESTING
//   - Reset: assert rst mid-stream with both stages valid -> out_valid=0,
//     ops_done=0, fa_a=0 immediately. After release, no stale result appears.
//   - Single op: req0 a=0x3FC00000 (1.5), b=0x3FC00000, out_ready=1
//     -> out_valid two cycles later, out_data=0x40400000 (3.0), out_id=0,
//     ops_done=1.
//   - Round robin: all 4 requesters valid for 8 cycles, out_ready=1
//     -> grant order 0,1,2,3,0,1,2,3, out_id in the same order, ops_done=8.
//   - Backpressure: 3 back-to-back ops with out_ready=0 -> 2 accepted,
//     req_ready=0 after that, out_data held. Raise out_ready -> all 3
//     results delivered in order, none lost.
//   - Wrap: req2 and req1 valid with ptr=3 -> req1 granted first, then req2.
//     Preload ops_done to 0xFFFFFFFF, one handshake -> 0.

Source files
------------

// File: rtl/fadd_rr_sched.sv
// Round-robin scheduler sharing one combinational float adder among N requesters.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i on bits [32*i+31:32*i]
//   fa_a/fa_b             operands to the shared adder, straight from the issue stage
//   fa_sum                adder result, combinational from fa_a/fa_b
//   out_valid/out_ready   result handshake
//   out_data/out_id       sum and the requester index that issued it
//   ops_done              count of completed output handshakes (wraps)
module fadd_rr_sched #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [31:0]       fa_a,
  output logic [31:0]       fa_b,
  input  logic [31:0]       fa_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [31:0]       ops_done
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = ID_W + 1;

  // Pipeline and arbiter state
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   s1_a_q, s1_a_d;
  logic [DW-1:0]   s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   s2_data_q, s2_data_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [DW-1:0]   ops_done_q, ops_done_d;

  logic            s2_adv, s1_adv, s1_load;
  logic            grant_found, accept, out_hs;
  logic [ID_W-1:0] grant_id;
  logic [PW-1:0]   idx;
  logic [DW-1:0]   a_arr [N];
  logic [DW-1:0]   b_arr [N];

  // Unpack the per-requester operand buses
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_arr[i] = req_a[DW*i +: DW];
      b_arr[i] = req_b[DW*i +: DW];
    end
  end

  // Stall network
  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = s1_valid_q && s2_adv;
    s1_load = !s1_valid_q || s2_adv;
    out_hs  = s2_valid_q && out_ready;
  end

  // Rotating priority search starting at ptr; idx is one bit wider so ptr+k never overflows
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'(ptr_q) + PW'(k);
      if (idx >= PW'(N)) idx = idx - PW'(N);
      if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  // Grant only when the issue stage can take it; nothing is offered during reset
  always_comb begin
    accept    = grant_found && s1_load && !rst;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    ops_done_d = ops_done_q + DW'(out_hs);

    // S1 data regs hold when the slot empties without a new request
    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = a_arr[grant_id];
        s1_b_d  = b_arr[grant_id];
        s1_id_d = grant_id;
        ptr_d   = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
      end
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = fa_sum;
      s2_id_d    = s1_id_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      ops_done_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign fa_a      = s1_a_q;
  assign fa_b      = s1_b_q;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_id    = s2_id_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_fadd_rr_sched.sv
// Bench for fadd_rr_sched: a FIFO-of-depth-two reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fadd_rr_sched;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a, req_b;
  logic [31:0]       fa_a, fa_b, fa_sum;
  logic              out_valid, out_ready;
  logic [31:0]       out_data;
  logic [ID_W-1:0]   out_id;
  logic [31:0]       ops_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in adder for positive normal floats (truncating), enough for the vectors used
  function automatic logic [31:0] fadd(input logic [31:0] x_in, input logic [31:0] y_in);
    logic [31:0] x, y;
    logic [7:0]  ex, ey;
    logic [24:0] mx, my;
    int          d;
    x = x_in; y = y_in;
    if (x[30:23] < y[30:23]) begin x = y_in; y = x_in; end
    if (x == 32'h0) return y;
    if (y == 32'h0) return x;
    ex = x[30:23]; ey = y[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    d  = int'(ex) - int'(ey);
    my = (d > 24) ? 25'h0 : (my >> d);
    mx = mx + my;
    if (mx[24]) begin mx = mx >> 1; ex = ex + 8'd1; end
    return {1'b0, ex, mx[22:0]};
  endfunction

  assign fa_sum = fadd(fa_a, fa_b);

  fadd_rr_sched #(.N(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .fa_a(fa_a), .fa_b(fa_b), .fa_sum(fa_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .ops_done(ops_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in-flight ops in accept order, at most two. An op becomes
  // visible at the output once it has survived one clock edge after its accept.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    int          age;
  } item_t;

  item_t       mq[$];
  int          m_ptr = 0;
  logic [31:0] m_a = '0, m_b = '0, m_ops = '0;
  int          acc_log[$];
  int          id_log[$];
  logic [31:0] dat_log[$];

  // Compare at the falling edge, then advance the model to the coming rising edge
  always @(negedge clk) begin
    logic        exp_ov, room, found;
    int          g;
    logic [N-1:0] exp_rdy;
    item_t       it;
    if (rst) begin
      mq.delete();
      m_ptr = 0; m_a = '0; m_b = '0; m_ops = '0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_ops_done", ops_done, 32'd0);
      check("rst_fa_a", fa_a, 32'd0);
    end else begin
      exp_ov = (mq.size() > 0) && (mq[0].age > 0);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        check("out_data", out_data, fadd(mq[0].a, mq[0].b));
        check("out_id", 32'(out_id), 32'(mq[0].id));
      end
      check("fa_a", fa_a, m_a);
      check("fa_b", fa_b, m_b);
      check("ops_done", ops_done, m_ops);

      room  = (mq.size() < 2) || out_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        int ix;
        ix = (m_ptr + k) % N;
        if (!found && req_valid[ix]) begin found = 1'b1; g = ix; end
      end
      exp_rdy = '0;
      if (found && room) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));

      for (int i = 0; i < mq.size(); i++) begin
        it = mq[i]; it.age = it.age + 1; mq[i] = it;
      end
      if (exp_ov && out_ready) begin
        it = mq.pop_front();
        id_log.push_back(it.id);
        dat_log.push_back(fadd(it.a, it.b));
        m_ops = m_ops + 32'd1;
      end
      if (found && room) begin
        it.a = req_a[32*g +: 32];
        it.b = req_b[32*g +: 32];
        it.id = g;
        it.age = 0;
        mq.push_back(it);
        acc_log.push_back(g);
        m_a = it.a; m_b = it.b;
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Single op: 1.5 + 1.5 = 3.0 from requester 0
    out_ready = 1'b1;
    set_op(0, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    check("single_s1_only", 32'(out_valid), 32'd0);
    check("single_fa_a", fa_a, 32'h3FC00000);
    cyc(1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'h40400000);
    check("single_id", 32'(out_id), 32'd0);
    cyc(1);
    check("single_ops_done", ops_done, 32'd1);
    check("single_drained", 32'(out_valid), 32'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    set_op(3, 32'h40000000, 32'h3F800000);
    req_valid = 4'b1000;
    cyc(2);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("rst_now_valid", 32'(out_valid), 32'd0);
    check("rst_now_ops", ops_done, 32'd0);
    check("rst_now_fa_a", fa_a, 32'd0);
    cyc(1);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(4);
    check("rst_no_stale", 32'(out_valid), 32'd0);

    // Round robin: all four valid for 8 cycles
    acc_log.delete(); id_log.delete();
    for (int i = 0; i < N; i++) set_op(i, 32'h3F800000, {1'b0, 8'(127 + i), 23'h0});
    req_valid = 4'b1111;
    cyc(8);
    req_valid = '0;
    cyc(3);
    check("rr_count", 32'(acc_log.size()), 32'd8);
    check("rr_out_count", 32'(id_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_log.size()) check("rr_grant", 32'(acc_log[i]), 32'(i % 4));
      if (i < id_log.size())  check("rr_out_id", 32'(id_log[i]), 32'(i % 4));
    end
    check("rr_ops_done", ops_done, 32'd8);

    // Backpressure: three ops, output stalled
    dat_log.delete();
    out_ready = 1'b0;
    set_op(0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0001;
    cyc(1);
    set_op(0, 32'h3F800000, 32'h40000000);
    cyc(1);
    set_op(0, 32'h40000000, 32'h40000000);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_head", out_data, 32'h40000000);
    cyc(3);
    check("bp_hold_ready", 32'(req_ready), 32'd0);
    check("bp_hold_data", out_data, 32'h40000000);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc(1);
    req_valid = '0;
    cyc(4);
    check("bp_delivered", 32'(dat_log.size()), 32'd3);
    if (dat_log.size() == 3) begin
      check("bp_res0", dat_log[0], 32'h40000000);
      check("bp_res1", dat_log[1], 32'h40400000);
      check("bp_res2", dat_log[2], 32'h40800000);
    end

    // Wrap: move ptr to 3, then req1 and req2 together
    set_op(1, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h40000000, 32'h3F800000);
    req_valid = 4'b0100;
    cyc(1);
    acc_log.delete();
    req_valid = 4'b0110;
    cyc(2);
    req_valid = '0;
    cyc(3);
    check("wrap_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      check("wrap_first", 32'(acc_log[0]), 32'd1);
      check("wrap_second", 32'(acc_log[1]), 32'd2);
    end

    // ops_done wrap from all-ones
    force dut.ops_done_q = 32'hFFFFFFFF;
    #1;
    release dut.ops_done_q;
    m_ops = 32'hFFFFFFFF;
    cyc(1);
    check("preload", ops_done, 32'hFFFFFFFF);
    set_op(0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    cyc(2);
    check("ops_wrap", ops_done, 32'd0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
